// File: rtl/alu_wb_pkg.sv
// Shared opcodes, register-file addresses and queue types for the ALU result
// writeback path.
package alu_wb_pkg;

  localparam logic [4:0] OP_MUL = 5'b01110;
  localparam logic [4:0] OP_DIV = 5'b01111;

  localparam int unsigned LO_ADDR_DEFAULT = 16;
  localparam int unsigned HI_ADDR_DEFAULT = 17;

  typedef enum logic {
    PH_FIRST  = 1'b0,
    PH_SECOND = 1'b1
  } phase_e;

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [63:0] data;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

  // MUL and DIV produce a 64-bit result that lands in the LO/HI pair.
  function automatic logic is_wide(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Generic synchronous FIFO with head-of-queue visibility and synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_res_fifo #(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    do_push  = push && (count_q != CW'(DEPTH));
    do_pop   = pop && (count_q != '0);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which slots are
  // valid, so stale contents are never observed.
  always_ff @(posedge Clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_writeback.sv
// Consumer end of the ALU result interface: queues tagged results and drains
// them through the single 32-bit register-file write port (wide ops as LO, HI).
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned RF_AW   = 5,
  parameter int unsigned LO_ADDR = LO_ADDR_DEFAULT,
  parameter int unsigned HI_ADDR = HI_ADDR_DEFAULT
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             res_valid,
  output logic             res_ready,
  input  logic [4:0]       res_op,
  input  logic [3:0]       res_rd,
  input  logic [63:0]      res_data,
  input  logic             rf_stall,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [31:0]      rf_wdata,
  output logic             wb_busy
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t          push_entry;
  wb_entry_t          head_entry;
  logic [ENTRY_W-1:0] head_bits;
  logic [CW-1:0]      count;
  logic               queue_full, queue_empty;
  logic               push, pop;
  phase_e             phase_q, phase_d;

  assign push_entry  = '{op: res_op, rd: res_rd, data: res_data};
  assign head_entry  = wb_entry_t'(head_bits);
  assign queue_full  = (count == CW'(DEPTH));
  assign queue_empty = (count == '0);

  // Readiness comes from the registered count only; a full queue does not
  // accept even when the head is popping in the same cycle.
  assign res_ready = !Clear && !queue_full;
  assign push      = res_valid && res_ready;
  assign wb_busy   = !Clear && !queue_empty;

  alu_res_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .Clock     (Clock),
    .Clear     (Clear),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_bits),
    .count     (count)
  );

  always_comb begin
    phase_d  = phase_q;
    pop      = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (!Clear && !queue_empty) begin
      if (phase_q == PH_SECOND) begin
        rf_waddr = RF_AW'(HI_ADDR);
        rf_wdata = head_entry.data[63:32];
        rf_we    = !rf_stall;
        if (!rf_stall) begin
          pop     = 1'b1;
          phase_d = PH_FIRST;
        end
      end else if (is_wide(head_entry.op)) begin
        rf_waddr = RF_AW'(LO_ADDR);
        rf_wdata = head_entry.data[31:0];
        rf_we    = !rf_stall;
        if (!rf_stall) phase_d = PH_SECOND;
      end else begin
        // r0 is hardwired: the entry is consumed but never written.
        rf_waddr = RF_AW'(head_entry.rd);
        rf_wdata = head_entry.data[31:0];
        rf_we    = !rf_stall && (head_entry.rd != 4'd0);
        if (!rf_stall) pop = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Clear) phase_q <= PH_FIRST;
    else       phase_q <= phase_d;
  end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: a queue-of-pending-writes model checked
// every cycle, plus directed cycles with hand-computed expectations.
module tb_alu_writeback;

  localparam int DEPTH = 2;

  logic        Clock = 1'b0;
  logic        Clear;
  logic        res_valid;
  logic        res_ready;
  logic [4:0]  res_op;
  logic [3:0]  res_rd;
  logic [63:0] res_data;
  logic        rf_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        wb_busy;

  always #5 Clock = ~Clock;

  alu_writeback #(
    .DEPTH   (DEPTH),
    .RF_AW   (5),
    .LO_ADDR (16),
    .HI_ADDR (17)
  ) dut (
    .Clock     (Clock),
    .Clear     (Clear),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_op    (res_op),
    .res_rd    (res_rd),
    .res_data  (res_data),
    .rf_stall  (rf_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .wb_busy   (wb_busy)
  );

  localparam logic [4:0] MUL = 5'b01110;
  localparam logic [4:0] DIV = 5'b01111;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Model: each accepted result becomes one or two register-file write slots;
  // the port drains one slot per unstalled cycle.
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    bit          we;
    bit          last;
  } slot_t;

  slot_t slots[$];
  int    n_entries = 0;
  bit    chk_en    = 1'b0;

  function automatic bit mdl_wide(input logic [4:0] op);
    return (op == 5'd14) || (op == 5'd15);
  endfunction

  always @(posedge Clock) begin
    bit accept;
    accept = !Clear && res_valid && (n_entries < DEPTH);
    if (Clear) begin
      slots.delete();
      n_entries = 0;
    end else begin
      if (slots.size() != 0 && !rf_stall) begin
        if (slots[0].last) n_entries--;
        void'(slots.pop_front());
      end
      if (accept) begin
        if (mdl_wide(res_op)) begin
          slots.push_back('{addr: 5'd16, data: res_data[31:0], we: 1'b1, last: 1'b0});
          slots.push_back('{addr: 5'd17, data: res_data[63:32], we: 1'b1, last: 1'b1});
        end else begin
          slots.push_back('{addr: {1'b0, res_rd}, data: res_data[31:0],
                            we: (res_rd != 4'd0), last: 1'b1});
        end
        n_entries++;
      end
    end
    chk_en = 1'b1;
  end

  always @(negedge Clock) begin
    logic        e_rdy, e_busy, e_we;
    logic [4:0]  e_a;
    logic [31:0] e_d;
    if (chk_en) begin
      e_rdy = 1'b0; e_busy = 1'b0; e_we = 1'b0; e_a = '0; e_d = '0;
      if (!Clear) begin
        e_rdy  = (n_entries < DEPTH);
        e_busy = (n_entries != 0);
        if (slots.size() != 0) begin
          e_a  = slots[0].addr;
          e_d  = slots[0].data;
          e_we = slots[0].we && !rf_stall;
        end
      end
      check("model res_ready", res_ready, e_rdy);
      check("model wb_busy",   wb_busy,   e_busy);
      check("model rf_we",     rf_we,     e_we);
      check("model rf_waddr",  rf_waddr,  e_a);
      check("model rf_wdata",  rf_wdata,  e_d);
    end
  end

  task automatic cyc();
    @(negedge Clock);
    @(posedge Clock);
    #1;
  endtask

  task automatic push(input logic [4:0] op, input logic [3:0] rd, input logic [63:0] d);
    res_valid = 1'b1;
    res_op    = op;
    res_rd    = rd;
    res_data  = d;
  endtask

  task automatic idle();
    res_valid = 1'b0;
  endtask

  // Hand-computed expectations for the current cycle, sampled after inputs settle.
  task automatic exp_cyc(input string name, input logic rdy, input logic busy,
                         input logic we, input logic [4:0] a, input logic [31:0] d);
    #1;
    check({name, " res_ready"}, res_ready, rdy);
    check({name, " wb_busy"},   wb_busy,   busy);
    check({name, " rf_we"},     rf_we,     we);
    check({name, " rf_waddr"},  rf_waddr,  a);
    check({name, " rf_wdata"},  rf_wdata,  d);
  endtask

  initial begin
    Clear = 1'b1; res_valid = 1'b0; res_op = '0; res_rd = '0; res_data = '0; rf_stall = 1'b0;
    cyc();
    exp_cyc("reset", 0, 0, 0, 5'd0, 32'h0);
    cyc();
    Clear = 1'b0;
    exp_cyc("post-reset", 1, 0, 0, 5'd0, 32'h0);
    cyc();

    // Narrow write
    push(5'b00000, 4'd3, 64'h8);         exp_cyc("narrow c0", 1, 0, 0, 5'd0, 32'h0);  cyc();
    idle();                              exp_cyc("narrow c1", 1, 1, 1, 5'd3, 32'h8);  cyc();
    exp_cyc("narrow c2", 1, 0, 0, 5'd0, 32'h0);

    // Wide write
    push(MUL, 4'd0, 64'h0000_0001_0000_0010); cyc();
    idle();                              exp_cyc("wide lo", 1, 1, 1, 5'd16, 32'h10);  cyc();
    exp_cyc("wide hi", 1, 1, 1, 5'd17, 32'h1);  cyc();
    exp_cyc("wide idle", 1, 0, 0, 5'd0, 32'h0);

    // Four back-to-back narrow results
    for (int i = 1; i <= 4; i++) begin
      push(5'b00011, 4'(i), 64'h100 + 64'(i));
      if (i == 1) exp_cyc("b2b first", 1, 0, 0, 5'd0, 32'h0);
      else        exp_cyc("b2b", 1, 1, 1, 5'(i - 1), 32'h100 + 32'(i - 1));
      cyc();
    end
    idle();                              exp_cyc("b2b last", 1, 1, 1, 5'd4, 32'h104); cyc();

    // MUL then two narrows: ready drops only during the HI write
    push(MUL, 4'd0, 64'hAAAA_BBBB_CCCC_DDDD); exp_cyc("mix c0", 1, 0, 0, 5'd0, 32'h0); cyc();
    push(5'b00001, 4'd5, 64'h55);        exp_cyc("mix lo", 1, 1, 1, 5'd16, 32'hCCCC_DDDD); cyc();
    push(5'b00001, 4'd6, 64'h66);        exp_cyc("mix hi", 0, 1, 1, 5'd17, 32'hAAAA_BBBB); cyc();
    exp_cyc("mix n1", 1, 1, 1, 5'd5, 32'h55); cyc();
    idle();                              exp_cyc("mix n2", 1, 1, 1, 5'd6, 32'h66);  cyc();
    exp_cyc("mix idle", 1, 0, 0, 5'd0, 32'h0);

    // Stall during the HI phase of a DIV with the queue full
    push(DIV, 4'd0, 64'h1234_5678_9ABC_DEF0); cyc();
    push(5'b00010, 4'd7, 64'h77);        exp_cyc("stall lo", 1, 1, 1, 5'd16, 32'h9ABC_DEF0); cyc();
    push(5'b00010, 4'd8, 64'h88);
    rf_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_cyc("stall hold", 0, 1, 0, 5'd17, 32'h1234_5678);
      cyc();
    end
    rf_stall = 1'b0;
    idle();                              exp_cyc("stall hi", 0, 1, 1, 5'd17, 32'h1234_5678); cyc();
    exp_cyc("stall n", 1, 1, 1, 5'd7, 32'h77); cyc();
    exp_cyc("stall idle", 1, 0, 0, 5'd0, 32'h0);

    // r0 suppression
    push(5'b00100, 4'd0, 64'h99);        cyc();
    idle();                              exp_cyc("r0 alone", 1, 1, 0, 5'd0, 32'h99); cyc();
    push(5'b00100, 4'd0, 64'h98);        exp_cyc("r0 drained", 1, 0, 0, 5'd0, 32'h0); cyc();
    push(5'b00100, 4'd9, 64'h9A);        exp_cyc("r0 again", 1, 1, 0, 5'd0, 32'h98);  cyc();
    idle();                              exp_cyc("r0 next", 1, 1, 1, 5'd9, 32'h9A);   cyc();

    // Clear after the LO write of a MUL
    push(MUL, 4'd0, 64'h0000_00EE_0000_00DD); exp_cyc("clr c0", 1, 0, 0, 5'd0, 32'h0); cyc();
    idle();                              exp_cyc("clr lo", 1, 1, 1, 5'd16, 32'hDD); cyc();
    Clear = 1'b1;                        exp_cyc("clr active", 0, 0, 0, 5'd0, 32'h0); cyc();
    Clear = 1'b0;
    push(5'b00101, 4'd2, 64'h22);        exp_cyc("clr after", 1, 0, 0, 5'd0, 32'h0); cyc();
    idle();                              exp_cyc("clr new", 1, 1, 1, 5'd2, 32'h22);  cyc();
    exp_cyc("clr idle", 1, 0, 0, 5'd0, 32'h0);

    // Randomised traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      int sel;
      sel       = $urandom_range(0, 3);
      res_valid = ($urandom_range(0, 9) < 7);
      res_op    = (sel == 0) ? MUL : (sel == 1) ? DIV : 5'($urandom_range(0, 31));
      res_rd    = 4'($urandom_range(0, 15));
      res_data  = {$urandom, $urandom};
      rf_stall  = ($urandom_range(0, 3) == 0);
      Clear     = ($urandom_range(0, 99) == 0);
      cyc();
    end

    Clear = 1'b0; rf_stall = 1'b0; idle();
    for (int i = 0; i < 6; i++) cyc();
    exp_cyc("drained", 1, 0, 0, 5'd0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Consumer end of the ALU result interface. Accepts results tagged with opcode and destination, buffers them in a 2-entry queue, and drains them through the register file's single 32-bit write port.
- 64-bit MUL/DIV results take two write cycles: LO first, then HI.
- Narrow results take one write cycle, using res_data[31:0].
- Sits between the ALU output register and the register file.

Parameters:
- DEPTH, 2, result queue entries (power of two, ≥2).
- RF_AW, 5, register file write-address width.
- LO_ADDR, 16, register file address of LO.
- HI_ADDR, 17, register file address of HI.

Ports:
- Clock  in  1  single clock, rising edge.
- Clear  in  1  synchronous reset, active high.
- res_valid  in  1  ALU result valid.
- res_ready  out  1  queue can accept a result.
- res_op  in  5  ALU Control code of the result.
- res_rd  in  4  destination GPR index; ignored for wide ops.
- res_data  in  64  ALU reg_C value.
- rf_stall  in  1  register file cannot accept a write this cycle.
- rf_we  out  1  register file write enable.
- rf_waddr  out  RF_AW  register file write address.
- rf_wdata  out  32  register file write data.
- wb_busy  out  1  queue non-empty.

Behaviour:
- Clock and reset: single clock Clock; Clear is synchronous, active high.
- Reset values (during Clear and the cycle after):
  - queue empty, count 0, phase PH_FIRST;
  - rf_we=0, rf_waddr=0, rf_wdata=0, wb_busy=0;
  - res_ready forced 0 while Clear=1, and inputs are ignored.
- Accept rule:
  - Push on the rising edge where res_valid && res_ready.
  - res_ready = !Clear && (count < DEPTH). It depends only on the registered count; no same-cycle bypass when full.
- Wide op: res_op == OP_MUL or OP_DIV. All other opcodes are narrow.
- Outputs are decoded combinationally from the registered queue head and phase. There is no output register, so the first write appears in the cycle after the accepting edge.
- Write FSM, states PH_FIRST and PH_SECOND:
  - PH_FIRST, head narrow: rf_waddr = {1'b0, rd}, rf_wdata = data[31:0].
    - rf_we = !rf_stall && rd != 0.
    - If !rf_stall: pop at the edge and stay in PH_FIRST.
  - PH_FIRST, head wide: rf_waddr = LO_ADDR, rf_wdata = data[31:0], rf_we = !rf_stall.
    - If !rf_stall: go to PH_SECOND with no pop.
  - PH_SECOND: rf_waddr = HI_ADDR, rf_wdata = data[63:32], rf_we = !rf_stall.
    - If !rf_stall: pop and return to PH_FIRST.
- Empty queue: rf_we=0, and rf_waddr and rf_wdata are driven to 0.
- rf_stall: forces rf_we=0 and holds the phase and head. rf_waddr and rf_wdata stay stable at the pending write.
- rd == 0 on a narrow op: the write is suppressed (r0 is not written) but the entry is still consumed.
- Simultaneous push and pop: count unchanged, pointers both advance. With continuous narrow traffic res_ready stays high.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- wb_busy = (count != 0).
- Clear mid-wide-op (after LO written, before HI): the entry is discarded and HI is never written. LO keeps the new value; this is not rolled back.
- Operands wider than 32 bits: only the selected half is written. No sign or zero extension.

Decomposition:
- Package alu_wb_pkg holds:
  - OP_MUL = 5'b01110 and OP_DIV = 5'b01111;
  - LO_ADDR and HI_ADDR defaults;
  - phase enum {PH_FIRST, PH_SECOND};
  - queue entry struct {op[4:0], rd[3:0], data[63:0]} (73 bits).
- Sub-module alu_res_fifo: generic synchronous DEPTH-entry FIFO with push, pop, head, count and synchronous Clear.
- The FSM and write decode live in alu_writeback.

Test Plan:
- Narrow write: op 5'b00000, rd 3, data 64'h8 accepted at edge N.
  - Cycle N+1: rf_we=1, rf_waddr=3, rf_wdata=32'h8.
  - Cycle N+2: rf_we=0, wb_busy=0.
- Wide write: op OP_MUL, data 64'h0000_0001_0000_0010 at edge N.
  - N+1: rf_waddr=16, rf_wdata=32'h10.
  - N+2: rf_waddr=17, rf_wdata=32'h1.
  - N+3: idle.
- Back-to-back traffic:
  - 4 narrow pushes on consecutive edges (rd 1..4): 4 consecutive writes and res_ready never drops.
  - MUL followed by 2 narrow pushes: res_ready low exactly during the HI-write cycle; writes appear in order LO, HI, n1, n2.
- Stall: rf_stall=1 for 3 cycles during PH_SECOND of a DIV.
  - rf_we=0, rf_waddr=17 and data held stable.
  - HI is written on the first unstalled cycle.
  - Queue full → res_ready=0 throughout.
- r0 suppression: narrow op with rd 0 → rf_we stays 0, wb_busy drops after one cycle, and the next entry is written in the following cycle.
- Clear after the LO write of a MUL:
  - No write to address 17 afterwards.
  - res_ready=0 in the Clear cycle, 1 in the next.
  - wb_busy=0, and a new narrow result is written normally.
